// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer:
// default geometry constants and the next-PC select encoding.
package pc_pkg;

    localparam int          DEFAULT_WIDTH        = 32;
    localparam int          DEFAULT_STEP         = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: a circular LIFO. A push into a full stack overwrites
// the oldest entry, because the write pointer simply wraps onto it. Entries
// are never cleared; reset only zeroes the count and pointer, which makes
// every stored entry invalid. Only used when PC_RAS_EN is defined.
module ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[wr_ptr - PTR_W'(1)];

    // Entry storage: written on every push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy: push saturates the count at DEPTH, pop on empty is a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential step, branch redirect,
// stall, and call/return through a return-address stack.
// Build option: define PC_RAS_EN to include the return-address stack; without
// it calls behave as branches, returns just step, and the stack outputs are 0.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int               RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         is_branch,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic [WIDTH-1:0]             newPC,
    output logic [WIDTH-1:0]             PC,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;

    assign pc_inc = PC + WIDTH'(STEP);

`ifdef PC_RAS_EN
    logic ras_full;
    logic push;
    logic pop;

    assign push = (sel == SEL_CALL);
    assign pop  = (sel == SEL_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Event flags: one-cycle pulses for a push that drops the oldest entry or a return with nothing stacked.
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= push && ras_full;
            ras_underflow <= !stall && is_ret && ras_empty;
        end
    end
`else
    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // Priority decode: stall, then return, call, branch, otherwise step; a return with an empty stack just steps.
    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (is_ret) begin
            sel = ras_empty ? SEL_INC : SEL_RET;
        end else if (is_call) begin
`ifdef PC_RAS_EN
            sel = SEL_CALL;
`else
            sel = SEL_BRANCH;
`endif
        end else if (is_branch) begin
            sel = SEL_BRANCH;
        end
    end

    // Next-PC mux driven by the decoded select.
    always_comb begin
        next_pc = pc_inc;
        case (sel)
            SEL_HOLD:   next_pc = PC;
            SEL_INC:    next_pc = pc_inc;
            SEL_BRANCH: next_pc = newPC;
            SEL_CALL:   next_pc = newPC;
            SEL_RET:    next_pc = ras_top;
            default:    next_pc = pc_inc;
        endcase
    end

    // PC register: reset loads the reset vector, otherwise takes the selected next address.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_VECTOR;
        end else begin
            PC <= next_pc;
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the CPU fetch stage: the next generation of the single-width PC register. It holds the current fetch address, advances it by a fixed step, and redirects on branch. It adds fetch stall, call/return handling with an on-chip return-address stack (RAS), and stack overflow/underflow reporting. Instantiated between the branch-resolution logic and instruction memory.

## Interface

- `WIDTH`, 32: address width in bits.
- `STEP`, 4: sequential increment added per advancing cycle.
- `RESET_VECTOR`, 0: PC value loaded on reset (`WIDTH` bits).
- `RAS_DEPTH`, 4: return-address stack entries, ≥2, power of two.

- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold the PC and stack; all other requests are ignored.
- `is_branch` input 1: redirect to `newPC`.
- `is_call` input 1: redirect to `newPC` and push the return address.
- `is_ret` input 1: redirect to the top of the RAS and pop.
- `newPC` input `WIDTH`: branch/call target.
- `PC` output `WIDTH`: current fetch address (registered).
- `ras_count` output `$clog2(RAS_DEPTH)+1`: valid RAS entries.
- `ras_overflow` output 1: one-cycle pulse, a push dropped the oldest entry.
- `ras_underflow` output 1: one-cycle pulse, a return occurred with an empty RAS.

## Operation

- Priority per edge: `reset` > `stall` > `is_ret` > `is_call` > `is_branch` > increment.
- Reset:
  - `PC` = `RESET_VECTOR`, `ras_count` = 0, both flags 0.
  - The RAS contents are invalidated.
  - A reset mid-operation discards all stack state in that same edge.
- Stall: `PC`, stack and `ras_count` hold; the flags are 0.
- Increment: `PC` ← (`PC` + `STEP`) mod 2^`WIDTH`. Wrap-around is silent.
- Branch: `PC` ← `newPC`, used unmodified (no alignment check).
- Call:
  - `PC` ← `newPC`, and push (`PC` + `STEP`) mod 2^`WIDTH`.
  - `is_branch` asserted in the same cycle is redundant.
  - RAS full on a call: the oldest entry is overwritten (circular), `ras_count` stays at `RAS_DEPTH`, and `ras_overflow` pulses.
- Return:
  - RAS non-empty: `PC` ← top entry, pop, `ras_count` − 1.
  - RAS empty: `PC` increments normally, `ras_underflow` pulses, `ras_count` stays 0.
- Simultaneous events:
  - `is_ret` with `is_call`: the return executes and the call is ignored (no push).
  - `is_ret` with `is_branch`: the return wins.

## Timing

- All outputs are registered.
- A request sampled at edge N is visible on `PC` after edge N (zero-bubble redirect, 1-cycle latency).
- `ras_count` and the flags update on the same edge as `PC`.
- Flags are high for exactly one cycle per event.
- There is no handshake. Requests are level inputs sampled every unstalled edge; holding `is_branch` high for k cycles redirects k times.

## Configuration

- `PC_RAS_EN` defined: RAS, call/return and flag behaviour exactly as above.
- `PC_RAS_EN` undefined:
  - No stack storage.
  - `is_call` behaves as `is_branch`.
  - `is_ret` is ignored (PC increments).
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.
  - Port list is unchanged.

## Structure

- Shared package `pc_pkg`:
  - Default `WIDTH`/`STEP`/`RESET_VECTOR` constants.
  - PC-select enum: `SEL_HOLD`, `SEL_INC`, `SEL_BRANCH`, `SEL_CALL`, `SEL_RET`.
- Sub-module `ras_stack`:
  - Circular LIFO with push/pop, top output, count, full/empty.
  - Synchronous reset clears the count and pointer.
  - Compiled only under `PC_RAS_EN`.
- Top level: priority decode into the select enum, the next-PC mux, and the PC register.

## Test plan

Defaults (`WIDTH`=32, `STEP`=4, `RESET_VECTOR`=0, `RAS_DEPTH`=4) unless stated.

- Reset pulse, then 5 free-running cycles -> `PC` = 0, 4, 8, 12, 16; `ras_count` = 0.
- Branch redirect: `is_branch`=1 for one cycle with `newPC`=32'hAAAAAAAA -> `PC`=AAAAAAAA, then AAAAAAAE.
- Stall: `stall`=1 for 3 cycles at `PC`=0x10, with `is_branch`=1 and `newPC`=0x80 during cycle 2 -> `PC` holds 0x10; after release `PC`=0x14.
- Call and return: at `PC`=0x20, call to 0x100 -> `PC`=0x100, `ras_count`=1. Two increments (`PC`=0x108), then `is_ret` -> `PC`=0x24, `ras_count`=0.
- Overflow and underflow:
  - 5 nested calls (return addresses R1..R5) -> `ras_overflow` pulses on call 5 only, `ras_count`=4.
  - 5 returns -> `PC` = R5, R4, R3, R2. On return 5, `ras_underflow` pulses and `PC` increments by 4.
- Wrap and reset mid-stack:
  - `PC`=32'hFFFFFFFC then increment -> `PC`=0.
  - With `ras_count`=3, assert `reset` -> next edge `PC`=0, `ras_count`=0. A following `is_ret` -> `ras_underflow` pulses.
  - Rerun with `PC_RAS_EN` undefined -> call acts as branch, `ras_count` always 0.
